// File: rtl/pipeline_trace_buffer_if.sv
// pipeline_trace_buffer_if: capture, read-port and statistics bus of the trace buffer
//   master (pipeline / debugger side) drives capture_en, instr, pc, npc, ctrl, s_in,
//   rd_req, stat_sel, stat_clr (and trig_arm, trig_class with TRACE_TRIGGER_EN);
//   slave (trace buffer) drives rd_valid, rd_instr, rd_pc, rd_npc, rd_ctrl, rd_s,
//   rd_class, count, overflow, stat_count (and trig_done with TRACE_TRIGGER_EN).
interface pipeline_trace_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int CTRL_W = 15,
    parameter int CNT_W  = 16
);
    logic                  capture_en;
    logic [31:0]           instr;
    logic [31:0]           pc;
    logic [31:0]           npc;
    logic [CTRL_W-1:0]     ctrl;
    logic                  s_in;
    logic                  rd_req;
    logic                  rd_valid;
    logic [31:0]           rd_instr;
    logic [31:0]           rd_pc;
    logic [31:0]           rd_npc;
    logic [CTRL_W-1:0]     rd_ctrl;
    logic                  rd_s;
    logic [3:0]            rd_class;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;
    logic [3:0]            stat_sel;
    logic [CNT_W-1:0]      stat_count;
    logic                  stat_clr;
`ifdef TRACE_TRIGGER_EN
    logic                  trig_arm;
    logic [3:0]            trig_class;
    logic                  trig_done;
`endif
    modport master (
        output capture_en, instr, pc, npc, ctrl, s_in, rd_req, stat_sel, stat_clr,
        input  rd_valid, rd_instr, rd_pc, rd_npc, rd_ctrl, rd_s, rd_class, count, overflow, stat_count
`ifdef TRACE_TRIGGER_EN
        , output trig_arm, trig_class, input trig_done
`endif
    );
    modport slave (
        input  capture_en, instr, pc, npc, ctrl, s_in, rd_req, stat_sel, stat_clr,
        output rd_valid, rd_instr, rd_pc, rd_npc, rd_ctrl, rd_s, rd_class, count, overflow, stat_count
`ifdef TRACE_TRIGGER_EN
        , input trig_arm, trig_class, output trig_done
`endif
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: circular trace capture of pipeline debug taps with per-class counters
//   clk, reset (async, active high); bus (slave modport of pipeline_trace_buffer_if):
//   capture side instr/pc/npc/ctrl/s_in qualified by capture_en; read side rd_req ->
//   rd_valid + rd_* one cycle later; count/overflow status; stat_sel/stat_count/stat_clr
//   class counters. Optional macro TRACE_TRIGGER_EN adds trig_arm/trig_class/trig_done,
//   a trigger that freezes capture POST_TRIG entries after a class match.
module pipeline_trace_buffer #(
    parameter int DEPTH     = 8,
    parameter int CTRL_W    = 15,
    parameter int CNT_W     = 16,
    parameter int POST_TRIG = 2
) (
    input logic clk,
    input logic reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 101 + CTRL_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POST_TRIG < 0) begin : g_bad_param
        $error("DEPTH must be a power of two >= 2 and POST_TRIG >= 0");
    end

    logic [EW-1:0]    mem [DEPTH];
    logic [CNT_W-1:0] cnt [16];
    logic [AW-1:0]    head, tail;
    logic [5:0]       op, fn;
    logic [3:0]       cls;
    logic             allow, wr, rd, full;

    assign op = bus.instr[31:26];
    assign fn = bus.instr[5:0];
    always_comb cls = op == 6'b001001 ? 4'd1 :
                      op == 6'b100100 ? 4'd2 :
                      op == 6'b000111 ? 4'd3 :
                      op == 6'b101000 ? 4'd4 :
                      op == 6'b000011 ? 4'd5 :
                      op == 6'b001111 ? 4'd6 :
                      op == 6'b000000 ? (fn == 6'b100011 ? 4'd7 : 4'd8) : 4'd0;

    assign full = bus.count == CW'(DEPTH);
    assign wr   = bus.capture_en & allow;
    assign rd   = bus.rd_req & (bus.count != '0);

    // A write into a full buffer without a pop evicts the oldest entry, so head follows tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            bus.rd_valid <= 1'b0;
            {bus.rd_instr, bus.rd_pc, bus.rd_npc, bus.rd_ctrl, bus.rd_s, bus.rd_class} <= '0;
        end else begin
            bus.rd_valid <= rd;
            if (rd)
                {bus.rd_instr, bus.rd_pc, bus.rd_npc, bus.rd_ctrl, bus.rd_s, bus.rd_class} <= mem[head];
            if (rd || (wr && full))
                head <= head + 1'b1;
            if (wr)
                tail <= tail + 1'b1;
            if (wr && !rd && !full)
                bus.count <= bus.count + 1'b1;
            else if (rd && !wr)
                bus.count <= bus.count - 1'b1;
            if (bus.stat_clr)
                bus.overflow <= 1'b0;
            else if (wr && !rd && full)
                bus.overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[tail] <= {bus.instr, bus.pc, bus.npc, bus.ctrl, bus.s_in, cls};
    end

    // Only indices 0..8 are ever incremented; the rest stay zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else if (bus.stat_clr) begin
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else if (wr && cnt[cls] != '1) begin
            cnt[cls] <= cnt[cls] + 1'b1;
        end
    end

    assign bus.stat_count = bus.stat_sel > 4'd8 ? '0 : cnt[bus.stat_sel];

`ifdef TRACE_TRIGGER_EN
    localparam int PW = $clog2(POST_TRIG + 1) + 1;
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} tstate_t;
    tstate_t       st, st_n;
    logic [PW-1:0] pcnt, pcnt_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= IDLE;
            pcnt <= '0;
        end else begin
            st   <= st_n;
            pcnt <= pcnt_n;
        end
    end

    // pcnt counts captures taken after the matching entry.
    always_comb begin
        st_n   = st;
        pcnt_n = pcnt;
        unique case (st)
            IDLE:  st_n = bus.trig_arm ? ARMED : IDLE;
            ARMED: if (wr && cls == bus.trig_class) begin
                pcnt_n = '0;
                st_n   = POST_TRIG == 0 ? DONE : POST;
            end
            POST:  if (wr) begin
                pcnt_n = pcnt + 1'b1;
                st_n   = pcnt_n == PW'(POST_TRIG) ? DONE : POST;
            end
            DONE:  st_n = bus.trig_arm ? IDLE : DONE;
        endcase
    end

    assign allow         = st != DONE;
    assign bus.trig_done = st == DONE;
`else
    assign allow = 1'b1;
`endif
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer: randomized scoreboard bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;
    localparam int DEPTH = 4, CTRL_W = 15, CNT_W = 3, POST_TRIG = 2, EW = 101 + CTRL_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_trace_buffer_if #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus();
    pipeline_trace_buffer #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .POST_TRIG(POST_TRIG))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int compared = 0, mismatched = 0;
    logic [EW-1:0] m_q[$];
    logic [EW-1:0] exp_q[$];
    int m_cnt[9];
    bit m_ovf = 0;
    int tst = 0, tn = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] klass(logic [31:0] i);
        case (i[31:26])
            6'b001001: return 4'd1;
            6'b100100: return 4'd2;
            6'b000111: return 4'd3;
            6'b101000: return 4'd4;
            6'b000011: return 4'd5;
            6'b001111: return 4'd6;
            6'b000000: return i[5:0] == 6'b100011 ? 4'd7 : 4'd8;
            default:   return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] gen();
        logic [5:0] ops [7];
        logic [31:0] r;
        int k;
        ops = '{6'b001001, 6'b100100, 6'b000111, 6'b101000, 6'b000011, 6'b001111, 6'b000000};
        r = $urandom;
        k = $urandom_range(0, 8);
        if (k < 7) r[31:26] = ops[k];
        if (k == 6 && $urandom_range(0, 1) == 1) r[5:0] = 6'b100011;
        return r;
    endfunction

    task automatic step(int p_cap, int p_rd);
        logic [3:0] c;
        bit w, r, allow, arm;
        @(negedge clk);
        bus.capture_en = $urandom_range(0, 99) < p_cap;
        bus.instr      = gen();
        bus.pc         = $urandom;
        bus.npc        = $urandom;
        bus.ctrl       = CTRL_W'($urandom);
        bus.s_in       = 1'($urandom);
        bus.rd_req     = $urandom_range(0, 99) < p_rd;
        bus.stat_sel   = 4'($urandom_range(0, 10));
        bus.stat_clr   = $urandom_range(0, 99) < 3;
        arm = 0;
`ifdef TRACE_TRIGGER_EN
        bus.trig_arm   = $urandom_range(0, 99) < 5;
        bus.trig_class = 4'($urandom_range(0, 8));
        arm   = bus.trig_arm;
        allow = tst != 3;
`else
        allow = 1;
`endif
        c = klass(bus.instr);
        w = bus.capture_en && allow;
        r = bus.rd_req && m_q.size() > 0;
        if (r) exp_q.push_back(m_q.pop_front());
        if (w) begin
            if (m_q.size() == DEPTH) begin
                m_q.delete(0);
                m_ovf = 1;
            end
            m_q.push_back({bus.instr, bus.pc, bus.npc, bus.ctrl, bus.s_in, c});
        end
        if (bus.stat_clr) begin
            m_cnt = '{default: 0};
            m_ovf = 0;
        end else if (w && m_cnt[c] < 2**CNT_W - 1) begin
            m_cnt[c]++;
        end
`ifdef TRACE_TRIGGER_EN
        if (tst == 0 && arm) tst = 1;
        else if (tst == 1 && w && c == bus.trig_class) begin
            tn  = 0;
            tst = POST_TRIG == 0 ? 3 : 2;
        end else if (tst == 2 && w) begin
            tn++;
            if (tn == POST_TRIG) tst = 3;
        end else if (tst == 3 && arm) tst = 0;
`else
        if (arm) tst = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.capture_en = 1'b0;
        bus.rd_req = 1'b0;
        bus.stat_clr = 1'b0;
`ifdef TRACE_TRIGGER_EN
        bus.trig_arm = 1'b0;
`endif
        m_q.delete();
        m_cnt = '{default: 0};
        m_ovf = 0;
        tst = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [EW-1:0] last = '0;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    always @(posedge clk) begin
        #1;
        got = {bus.rd_instr, bus.rd_pc, bus.rd_npc, bus.rd_ctrl, bus.rd_s, bus.rd_class};
        if (reset) last = '0;
        chk("rd_valid", bus.rd_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.rd_valid) last = e;
        end
        chk("rd_data", got, last);
        chk("count", bus.count, m_q.size());
        chk("overflow", bus.overflow, m_ovf);
        chk("stat_count", bus.stat_count, bus.stat_sel > 8 ? 0 : m_cnt[bus.stat_sel]);
`ifdef TRACE_TRIGGER_EN
        chk("trig_done", bus.trig_done, tst == 3);
`endif
    end

    int caps [8] = '{90, 20, 60, 100, 50, 95, 10, 70};
    int rds  [8] = '{10, 90, 60, 100, 50, 5, 80, 30};

    initial begin
        bus.capture_en = 0; bus.instr = 0; bus.pc = 0; bus.npc = 0; bus.ctrl = 0; bus.s_in = 0;
        bus.rd_req = 0; bus.stat_sel = 0; bus.stat_clr = 0;
`ifdef TRACE_TRIGGER_EN
        bus.trig_arm = 0; bus.trig_class = 0;
`endif
        m_cnt = '{default: 0};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 300; i++) step(caps[p], rds[p]);
            if (p == 3 || p == 6) do_reset();
        end
        repeat (DEPTH + 2) step(0, 100);
        repeat (3) step(0, 0);
        @(negedge clk);
        chk("drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
